button_debouncer: RTL

Front-end conditioning stage directly upstream of `button_counter`. It synchronises the raw mechanical button input into the `clk` domain, filters contact bounce with a per-transition stability counter, and emits a clean debounced level plus single-cycle press and release event pulses. `button_counter` consumes `press_pulse`, so every event it counts, and therefore every entry `memory_driver` stores, is one genuine press.

---
 rtl/button_pkg.sv | 16 +
 rtl/sync_2ff.sv | 26 ++
 rtl/button_debouncer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/button_pkg.sv
// Shared definitions for the button front-end: debouncer FSM state encoding
// and default timing constants (also imported by button_counter).
package button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_e;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEF_LONG_CYCLES     = 16;
    localparam int unsigned DEF_CNT_W           = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, async active-low reset.
module sync_2ff #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/button_debouncer.sv
// Synchronises and debounces a raw button, producing a clean level plus
// press/release pulses; optional long-press pulse under BTN_LONG_PRESS_EN.
module button_debouncer
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_param
        $error("button_debouncer: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 1");
    end

    // The sample that leaves a stable state is the first stable cycle, so the
    // wait states accept once DEBOUNCE_CYCLES-2 further increments are seen.
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam bit               DB_ONE  = (DEBOUNCE_CYCLES == 1);

    logic             s2;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    sync_2ff #(.W(1)) u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (btn_raw),
        .q     (s2)
    );

    always_comb begin
        cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s2) begin
                    cnt_d = '0;
                    if (DB_ONE) begin
                        state_d = PRESSED;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        state_d = PRESS_WAIT;
                    end
                end
            end
            PRESS_WAIT: begin
                if (!s2) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = PRESSED;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            PRESSED: begin
                if (!s2) begin
                    cnt_d = '0;
                    if (DB_ONE) begin
                        state_d   = IDLE;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        state_d = RELEASE_WAIT;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (s2) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

`ifdef BTN_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

    logic [CNT_W-1:0] hold_q, hold_d;
    logic             long_done_q, long_done_d;
    logic             long_q, long_d;
    logic             stay_pressed;

    // Hold count only advances while PRESSED persists; any (re)entry restarts it.
    always_comb begin
        stay_pressed = (state_q == PRESSED) && (state_d == PRESSED);
        hold_d       = '0;
        long_d       = 1'b0;
        long_done_d  = press_d ? 1'b0 : long_done_q;
        if (stay_pressed) begin
            hold_d = (hold_q == '1) ? hold_q : hold_q + 1'b1;
            if (!long_done_q && hold_q == LONG_LAST) begin
                long_d      = 1'b1;
                long_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q      <= '0;
            long_done_q <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            long_done_q <= long_done_d;
            long_q      <= long_d;
        end
    end

    assign long_pulse = long_q;
`else
    assign long_pulse = 1'b0;
`endif

endmodule
